// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer and the 1010 detector.
// State encoding and default word width.
package seq_serializer_pkg;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/seq_serializer_bit_counter.sv
// Mod-WIDTH bit counter with sync clear, load-zero
// and terminal-count flag.
module bit_counter
  import seq_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CW'(WIDTH-1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-in/serial-out stage feeding the 1010
// detector; gap-free across back-to-back words.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sout_q, sout_d;
  logic             sv_q, sv_d;
  logic             last_q, last_d;

  logic [CW-1:0]    cnt;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_en;
  logic             accept;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  assign ready = (state_q == S_IDLE) ||
                 ((state_q == S_SHIFT) && tc);
  assign accept = valid && ready && !reset;

  assign sout       = sout_q;
  assign sout_valid = sv_q;
  assign last       = last_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    sout_d  = sout_q;
    sv_d    = sv_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (accept) begin
      state_d = S_SHIFT;
      sh_d    = din;
      sout_d  = MSB_FIRST ? din[WIDTH-1] : din[0];
      sv_d    = 1'b1;
      last_d  = 1'b0;
      cnt_clr = 1'b1;
    end else if (state_q == S_SHIFT) begin
      if (tc) begin
        state_d = S_IDLE;
        sout_d  = 1'b0;
        sv_d    = 1'b0;
        last_d  = 1'b0;
        cnt_clr = 1'b1;
      end else begin
        // next bit comes from the register before this shift
        sh_d   = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
        sout_d = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
        last_d = (cnt == CW'(WIDTH-2));
        cnt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      sout_q  <= 1'b0;
      sv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: MSB-first and
// LSB-first instances plus a 1010 detector model.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din_m, din_l;
  logic       valid_m, valid_l;
  logic       ready_m, sout_m, sv_m, last_m;
  logic       ready_l, sout_l, sv_l, last_l;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .din        (din_m),
    .valid      (valid_m),
    .ready      (ready_m),
    .sout       (sout_m),
    .sout_valid (sv_m),
    .last       (last_m)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .din        (din_l),
    .valid      (valid_l),
    .ready      (ready_l),
    .sout       (sout_l),
    .sout_valid (sv_l),
    .last       (last_l)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  q_m[$];
  logic [1:0]  q_l[$];
  logic [1:0]  e_m, e_l;
  bit          mon_en = 1'b0;
  bit          sys_on = 1'b0;
  int          sys_idx = 0;
  logic [3:0]  hist = '0;
  logic [15:0] det_mask = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push_m(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++)
      q_m.push_back({w[7-i], i == 7});
  endtask

  task automatic push_l(input logic [7:0] w);
    for (int i = 0; i < 8; i++)
      q_l.push_back({w[i], i == 7});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // MSB-first monitor and 1010 detector model
  always @(negedge clk) begin
    if (mon_en) begin
      if (sv_m === 1'b1) begin
        if (q_m.size() == 0) begin
          chk("m_extra_bit", 1, 0);
        end else begin
          e_m = q_m.pop_front();
          chk("m_sout", sout_m, e_m[1]);
          chk("m_last", last_m, e_m[0]);
        end
        if (sys_on) begin
          hist = (sys_idx == 0) ? {3'b000, sout_m}
                                : {hist[2:0], sout_m};
          if (hist == 4'b1010 && sys_idx < 16)
            det_mask[sys_idx] = 1'b1;
          sys_idx++;
        end
      end else begin
        chk("m_idle", {sv_m, sout_m, last_m}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (sv_l === 1'b1) begin
        if (q_l.size() == 0) begin
          chk("l_extra_bit", 1, 0);
        end else begin
          e_l = q_l.pop_front();
          chk("l_sout", sout_l, e_l[1]);
          chk("l_last", last_l, e_l[0]);
        end
      end else begin
        chk("l_idle", {sv_l, sout_l, last_l}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_m = 1'b0;
    valid_l = 1'b0;
    din_m   = '0;
    din_l   = '0;
    reset   = 1'b1;
    tick;
    tick;
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_ready", ready_m, 1);
    chk("rst_sout", sout_m, 0);
    chk("rst_sv", sv_m, 0);
    chk("rst_last", last_m, 0);
    chk("rst_ready_l", ready_l, 1);

    // single word
    din_m   = 8'hAA;
    valid_m = 1'b1;
    push_m(8'hAA, 8);
    tick;
    valid_m = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("t1_ready", ready_m, (j == 7));
      chk("t1_sv", sv_m, 1);
      tick;
    end
    chk("t1_ready_end", ready_m, 1);
    chk("t1_sv_end", sv_m, 0);

    // back-to-back
    din_m   = 8'hA5;
    valid_m = 1'b1;
    push_m(8'hA5, 8);
    tick;
    din_m = 8'h0F;
    for (int j = 0; j < 16; j++) begin
      chk("t2_ready", ready_m, (j == 7 || j == 15));
      chk("t2_sv", sv_m, 1);
      if (j == 7) push_m(8'h0F, 8);
      tick;
      if (j == 7) valid_m = 1'b0;
    end
    chk("t2_sv_end", sv_m, 0);

    // valid outside ready is ignored
    din_m   = 8'h3C;
    valid_m = 1'b1;
    push_m(8'h3C, 8);
    tick;
    valid_m = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("t3_ready", ready_m, (j == 7));
      valid_m = (j >= 2 && j <= 6);
      din_m   = 8'($urandom);
      tick;
    end
    valid_m = 1'b0;
    tick;
    tick;
    chk("t3_no_extra", q_m.size(), 0);
    chk("t3_ready_end", ready_m, 1);

    // reset during bit 3, valid offered in reset cycle
    din_m   = 8'hFF;
    valid_m = 1'b1;
    push_m(8'hFF, 4);
    tick;
    valid_m = 1'b0;
    tick;
    tick;
    tick;
    reset   = 1'b1;
    valid_m = 1'b1;
    din_m   = 8'h81;
    tick;
    reset   = 1'b0;
    valid_m = 1'b0;
    chk("t4_sout", sout_m, 0);
    chk("t4_sv", sv_m, 0);
    chk("t4_last", last_m, 0);
    chk("t4_ready", ready_m, 1);
    tick;
    chk("t4_no_accept", sv_m, 0);
    din_m   = 8'h81;
    valid_m = 1'b1;
    push_m(8'h81, 8);
    tick;
    valid_m = 1'b0;
    repeat (8) tick;
    chk("t4_drained", q_m.size(), 0);

    // LSB first
    din_l   = 8'h05;
    valid_l = 1'b1;
    push_l(8'h05);
    tick;
    valid_l = 1'b0;
    repeat (8) tick;
    chk("t5_drained", q_l.size(), 0);
    chk("t5_ready", ready_l, 1);

    // system: 5A then A0 into 1010 detector model
    sys_idx  = 0;
    det_mask = '0;
    sys_on   = 1'b1;
    din_m    = 8'h5A;
    valid_m  = 1'b1;
    push_m(8'h5A, 8);
    tick;
    din_m = 8'hA0;
    repeat (7) tick;
    push_m(8'hA0, 8);
    tick;
    valid_m = 1'b0;
    repeat (8) tick;
    sys_on = 1'b0;
    chk("t6_bits", sys_idx, 16);
    chk("t6_det_mask", det_mask, 16'h0A80);
    chk("t6_drained", q_m.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-in/serial-out stage that sits directly upstream of the `seq_1010` sequence detector: it accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto a serial line wired to the detector's `in`. Back-to-back words produce a gap-free bit stream, so patterns spanning a word boundary are still detected. A qualifier (`sout_valid`) and a last-bit flag let downstream logic tell stream bits from idle fill.

## Interface
- `WIDTH`, 8, word width in bits; legal range 2..32.
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high; returns the block to IDLE on the next rising edge.
- `din`  input  WIDTH  parallel word; sampled only on an accepting edge.
- `valid`  input  1  `din` is offered.
- `ready`  output  1  block can accept a word this cycle.
- `sout`  output  1  serial data to the detector `in`; registered.
- `sout_valid`  output  1  `sout` carries a stream bit; registered.
- `last`  output  1  `sout` holds the final bit of the current word; registered.

## Operation
- States: IDLE, SHIFT. Encoding lives in the shared header.
- IDLE: `ready`=1, `sout`=0, `sout_valid`=0, `last`=0.
- Accept = rising edge with `valid`=1, `ready`=1 and `reset`=0. On accept:
  - capture `din` into the shift register;
  - load the first bit into `sout`;
  - set `sout_valid`=1 and bit count = 0;
  - go to SHIFT.
- SHIFT, each edge while count < WIDTH-1: shift, present the next bit, count+1. `last`=1 exactly when count = WIDTH-1.
- `ready` = (state==IDLE) or (state==SHIFT and count==WIDTH-1). It is combinational from state/count and never depends on `valid`.
- End of word (edge leaving count = WIDTH-1):
  - if accepting: reload from the new `din`, first bit on `sout`, count=0, stay in SHIFT. No idle cycle is inserted.
  - else: go to IDLE; `sout`=0 and `sout_valid`=0 on the same edge.
- `valid` outside a `ready` cycle is ignored. `din` changes mid-word do not affect bits in flight.
- Bit order per `MSB_FIRST`, fixed at elaboration.
- Reset, including mid-word: the current word is discarded with no partial flush. After the edge: IDLE, `sout`=0, `sout_valid`=0, `last`=0, `ready`=1, count=0, shift register=0. `valid` in the reset cycle is not accepted.
- Counter width: $clog2(WIDTH). It never exceeds WIDTH-1 and does not wrap.

## Timing
- Latency: accept at edge k puts bit 0 of the word on `sout` after edge k. Bit i appears after edge k+i, for i = 0..WIDTH-1.
- Throughput: one word per WIDTH cycles when `valid` is held high; 100% line utilisation.
- `last` is high for exactly one cycle per word, aligned with its final bit.
- Reset values of all outputs: `sout`=0, `sout_valid`=0, `last`=0, `ready`=1.
- The detector samples `sout` on the same `clk`, so each serial bit is seen exactly once.

## Structure
- Shared header `seq_defs.vh` holds:
  - state localparams `S_IDLE`=1'b0 and `S_SHIFT`=1'b1;
  - the default `WIDTH`.
  The detector and this block both include it.
- One sub-module: `bit_counter`, a parameterised mod-WIDTH up-counter with synchronous clear, load-zero and terminal-count output, which drives `last`/`ready`.
- Shift register and bit-order select stay inline in `seq_serializer`.

## Test plan
- Single word: WIDTH=8, MSB_FIRST=1, `din`=8'hAA, one-cycle `valid`.
  - `sout`=1,0,1,0,1,0,1,0 on the 8 cycles after accept.
  - `sout_valid` high for exactly 8 cycles; `last` only on the 8th.
  - `ready` then returns to 1.
- Back-to-back: `valid` held with `din`=8'hA5 then 8'h0F.
  - 16 contiguous valid bits: 1010 0101 0000 1111.
  - `ready` high only on the 8th and 16th bit cycles.
  - No `sout_valid` gap.
- Ignored traffic: `valid`=1 with changing `din` during bits 2–6 of word 8'h3C.
  - Output stays 0,0,1,1,1,1,0,0.
  - No extra word is accepted.
- Reset mid-word: assert `reset` during bit 3 of 8'hFF.
  - Next cycle: `sout`=0, `sout_valid`=0, `last`=0, `ready`=1.
  - A following 8'h81 serialises cleanly as 1,0,0,0,0,0,0,1.
- LSB first: MSB_FIRST=0, `din`=8'h05.
  - `sout`=1,0,1,0,0,0,0,0.
- System test, serializer driving `seq_1010` `in`: words 8'h5A then 8'hA0.
  - Detector `out` pulses at the pattern inside 8'h5A.
  - Detector `out` also pulses at the 1010 formed across the word boundary, confirming the stream is gap-free.
